// File: rtl/piece_drop_ctrl_pkg.sv
// piece_drop_ctrl_pkg: board geometry and FSM encoding shared by the drop controller and the row finder.
package piece_drop_ctrl_pkg;
    localparam int NUM_COLS = 7;
    localparam int NUM_ROWS = 6;
    localparam int COL_W    = 3;
    localparam int CNT_W    = 6;
    localparam logic [CNT_W-1:0] TOTAL_CELLS = CNT_W'(NUM_COLS * NUM_ROWS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REJECT,
        S_SHIFT,
        S_DRAW,
        S_WAIT
    } state_e;
endpackage

// File: rtl/piece_drop_ctrl_column_store.sv
// column_store: per-column thermometer occupancy registers with shift-in, clear and column readout.
module column_store
    import piece_drop_ctrl_pkg::*;
#(
    parameter int NUM_COLS = piece_drop_ctrl_pkg::NUM_COLS,
    parameter int NUM_ROWS = piece_drop_ctrl_pkg::NUM_ROWS
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                clr_i,
    input  logic                shift_en_i,
    input  logic [COL_W-1:0]    sel_i,
    output logic [NUM_ROWS-1:0] col_o,
    output logic                top_o
);
    logic [NUM_ROWS-1:0] cols_q [NUM_COLS];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < NUM_COLS; c++) cols_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (clr_i)
                    cols_q[c] <= '0;
                else if (shift_en_i && sel_i == COL_W'(c))
                    cols_q[c] <= {cols_q[c][NUM_ROWS-2:0], 1'b1};
            end
        end
    end

    // An out-of-range select reads as an empty column.
    always_comb begin
        col_o = '0;
        for (int c = 0; c < NUM_COLS; c++)
            if (sel_i == COL_W'(c)) col_o = cols_q[c];
    end

    assign top_o = col_o[NUM_ROWS-1];
endmodule

// File: rtl/piece_drop_ctrl.sv
// piece_drop_ctrl: validates column drops, updates occupancy, and handshakes each accepted piece with the VGA drawer.
module piece_drop_ctrl
#(
    parameter int NUM_COLS = piece_drop_ctrl_pkg::NUM_COLS,
    parameter int NUM_ROWS = piece_drop_ctrl_pkg::NUM_ROWS
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                drop_req,
    input  logic [2:0]          drop_col,
    input  logic                new_game,
    input  logic                draw_done,
    output logic [NUM_ROWS-1:0] onoff_val,
    output logic [2:0]          vga_col,
    output logic                player,
    output logic                draw_start,
    output logic                drop_reject,
    output logic                busy,
    output logic                board_full
);
    import piece_drop_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] CELLS = CNT_W'(NUM_COLS * NUM_ROWS);

    state_e              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d, vga_q, vga_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                player_q, player_d;
    logic [NUM_ROWS-1:0] onoff_q, onoff_d, col_val;
    logic                col_top, clr, shift_en;

    column_store #(.NUM_COLS(NUM_COLS), .NUM_ROWS(NUM_ROWS)) u_store (
        .clk        (clk),
        .resetn     (resetn),
        .clr_i      (clr),
        .shift_en_i (shift_en),
        .sel_i      (col_q),
        .col_o      (col_val),
        .top_o      (col_top)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            vga_q    <= '0;
            cnt_q    <= '0;
            player_q <= 1'b0;
            onoff_q  <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            vga_q    <= vga_d;
            cnt_q    <= cnt_d;
            player_q <= player_d;
            onoff_q  <= onoff_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        vga_d    = vga_q;
        cnt_d    = cnt_q;
        player_d = player_q;
        onoff_d  = onoff_q;
        clr      = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (new_game) begin
                    clr      = 1'b1;
                    cnt_d    = '0;
                    player_d = 1'b0;
                end else if (drop_req) begin
                    col_d   = drop_col;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: state_d = (32'(col_q) >= NUM_COLS || col_top || board_full) ? S_REJECT : S_SHIFT;
            S_REJECT: state_d = S_IDLE;
            S_SHIFT: begin
                shift_en = 1'b1;
                vga_d    = col_q;
                onoff_d  = {col_val[NUM_ROWS-2:0], 1'b1};
                cnt_d    = (cnt_q == CELLS) ? cnt_q : cnt_q + 1'b1;
                state_d  = S_DRAW;
            end
            S_DRAW: state_d = S_WAIT;
            S_WAIT: begin
                if (draw_done) begin
                    player_d = ~player_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign onoff_val   = onoff_q;
    assign vga_col     = vga_q;
    assign player      = player_q;
    assign draw_start  = (state_q == S_DRAW);
    assign drop_reject = (state_q == S_REJECT);
    assign busy        = (state_q != S_IDLE);
    assign board_full  = (cnt_q == CELLS);
endmodule
